// File: rtl/fft_defs.sv
// Shared FFT definitions: default widths, complex sample type, FSM encoding,
// and the rounding / saturation helpers used by the butterfly datapaths.
package fft_defs;

    localparam int DW_DEF   = 10;
    localparam int FRAC_DEF = 5;

    typedef struct packed {
        logic signed [DW_DEF-1:0] re;
        logic signed [DW_DEF-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } stage_state_t;

    // Round half-up, then arithmetic shift right by frac.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] x,
                                                       input int frac);
        logic signed [63:0] half;
        half = (frac > 0) ? (64'sd1 <<< (frac - 1)) : 64'sd0;
        return (x + half) >>> frac;
    endfunction

    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] x,
                                                    input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi)      return hi;
        else if (x < lo) return lo;
        else             return x;
    endfunction

    function automatic logic sat_hit(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (x > hi) || (x < lo);
    endfunction

endpackage

// File: rtl/fft_stage_seq_if.sv
// Frame-level handshake bundle of the sequential radix-2 FFT stage.
interface fft_stage_seq_if #(
    parameter int N_PTS = 32,
    parameter int DW    = fft_defs::DW_DEF
);
    logic                       in_valid;
    logic                       in_ready;
    logic [N_PTS*DW-1:0]        in_real;
    logic [N_PTS*DW-1:0]        in_imag;
    logic [(N_PTS/2)*DW-1:0]    tw_real;
    logic [(N_PTS/2)*DW-1:0]    tw_imag;
    logic                       scale_en;
    logic                       out_valid;
    logic                       out_ready;
    logic [N_PTS*DW-1:0]        out_real;
    logic [N_PTS*DW-1:0]        out_imag;
    logic                       busy;
    logic                       ovf;

    modport master (
        output in_valid, in_real, in_imag, tw_real, tw_imag, scale_en, out_ready,
        input  in_ready, out_valid, out_real, out_imag, busy, ovf
    );

    modport slave (
        input  in_valid, in_real, in_imag, tw_real, tw_imag, scale_en, out_ready,
        output in_ready, out_valid, out_real, out_imag, busy, ovf
    );
endinterface

// File: rtl/fft_bfly_r2.sv
// Combinational radix-2 butterfly: y_top = a + b*w, y_bot = a - b*w,
// with optional halving and saturation to DW bits.
module fft_bfly_r2
    import fft_defs::*;
#(
    parameter int DW   = DW_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [DW-1:0] w_re,
    input  logic signed [DW-1:0] w_im,
    input  logic                 scale_en,
    output logic signed [DW-1:0] y_top_re,
    output logic signed [DW-1:0] y_top_im,
    output logic signed [DW-1:0] y_bot_re,
    output logic signed [DW-1:0] y_bot_im,
    output logic                 sat
);
    localparam int PW = 2 * DW;
    localparam int SW = DW + 2;

    logic signed [PW-1:0] m_rr, m_ii, m_ri, m_ir;
    logic signed [PW:0]   pr_full, pi_full;
    logic signed [SW-1:0] p_re, p_im;
    logic signed [SW-1:0] t_re, t_im, u_re, u_im;

    always_comb begin
        m_rr    = PW'(b_re) * PW'(w_re);
        m_ii    = PW'(b_im) * PW'(w_im);
        m_ri    = PW'(b_re) * PW'(w_im);
        m_ir    = PW'(b_im) * PW'(w_re);
        pr_full = (PW+1)'(m_rr) - (PW+1)'(m_ii);
        pi_full = (PW+1)'(m_ri) + (PW+1)'(m_ir);
        p_re    = SW'(round_shift(64'(pr_full), FRAC));
        p_im    = SW'(round_shift(64'(pi_full), FRAC));

        // Sum and difference live at DW+2 bits before optional halving.
        t_re = SW'(a_re) + p_re;
        t_im = SW'(a_im) + p_im;
        u_re = SW'(a_re) - p_re;
        u_im = SW'(a_im) - p_im;
        if (scale_en) begin
            t_re = t_re >>> 1;
            t_im = t_im >>> 1;
            u_re = u_re >>> 1;
            u_im = u_im >>> 1;
        end

        y_top_re = DW'(sat_clip(64'(t_re), DW));
        y_top_im = DW'(sat_clip(64'(t_im), DW));
        y_bot_re = DW'(sat_clip(64'(u_re), DW));
        y_bot_im = DW'(sat_clip(64'(u_im), DW));
        sat      = sat_hit(64'(t_re), DW) | sat_hit(64'(t_im), DW) |
                   sat_hit(64'(u_re), DW) | sat_hit(64'(u_im), DW);
    end
endmodule

// File: rtl/fft_stage_seq.sv
// Time-multiplexed radix-2 FFT stage: captures a frame, runs LANES butterflies
// per cycle for N_PTS/(2*LANES) cycles, then holds the result until taken.
module fft_stage_seq
    import fft_defs::*;
#(
    parameter int N_PTS = 32,
    parameter int DW    = DW_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int LANES = 4,
    parameter int SPAN  = 16
) (
    input  logic            clk,
    input  logic            rst,
    fft_stage_seq_if.slave  bus
);
    localparam int NB = N_PTS / 2;
    localparam int C  = NB / LANES;
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam int IW = $clog2(N_PTS);
    localparam int BW = $clog2(NB);

    stage_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;
    logic          last;

    logic signed [DW-1:0] x_re [N_PTS];
    logic signed [DW-1:0] x_im [N_PTS];
    logic signed [DW-1:0] w_re [NB];
    logic signed [DW-1:0] w_im [NB];
    logic                 scl_q;
    logic signed [DW-1:0] y_re [N_PTS];
    logic signed [DW-1:0] y_im [N_PTS];
    logic                 ovf_q;

    logic [BW-1:0]        b_idx   [LANES];
    logic [IW-1:0]        top_idx [LANES];
    logic [IW-1:0]        bot_idx [LANES];
    logic signed [DW-1:0] yt_re [LANES];
    logic signed [DW-1:0] yt_im [LANES];
    logic signed [DW-1:0] yb_re [LANES];
    logic signed [DW-1:0] yb_im [LANES];
    logic [LANES-1:0]     sat_v;

    assign bus.in_ready  = (state_q == ST_IDLE) & rst;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.ovf       = ovf_q;
    assign accept        = bus.in_valid & bus.in_ready;
    assign last          = (cnt_q == CW'(C - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                state_d = ST_CALC;
                cnt_d   = '0;
            end
            ST_CALC: begin
                cnt_d = last ? '0 : cnt_q + 1'b1;
                if (last) state_d = ST_DONE;
            end
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture holds no control meaning, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < N_PTS; k++) begin
                x_re[k] <= bus.in_real[k*DW +: DW];
                x_im[k] <= bus.in_imag[k*DW +: DW];
            end
            for (int b = 0; b < NB; b++) begin
                w_re[b] <= bus.tw_real[b*DW +: DW];
                w_im[b] <= bus.tw_imag[b*DW +: DW];
            end
            scl_q <= bus.scale_en;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign b_idx[l]   = BW'(int'(cnt_q) * LANES + l);
        assign top_idx[l] = IW'((int'(b_idx[l]) / SPAN) * 2 * SPAN + int'(b_idx[l]) % SPAN);
        assign bot_idx[l] = top_idx[l] + IW'(SPAN);

        fft_bfly_r2 #(.DW(DW), .FRAC(FRAC)) u_bfly (
            .a_re     (x_re[top_idx[l]]),
            .a_im     (x_im[top_idx[l]]),
            .b_re     (x_re[bot_idx[l]]),
            .b_im     (x_im[bot_idx[l]]),
            .w_re     (w_re[b_idx[l]]),
            .w_im     (w_im[b_idx[l]]),
            .scale_en (scl_q),
            .y_top_re (yt_re[l]),
            .y_top_im (yt_im[l]),
            .y_bot_re (yb_re[l]),
            .y_bot_im (yb_im[l]),
            .sat      (sat_v[l])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_PTS; k++) begin
                y_re[k] <= '0;
                y_im[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (state_q == ST_CALC) begin
            for (int l = 0; l < LANES; l++) begin
                y_re[top_idx[l]] <= yt_re[l];
                y_im[top_idx[l]] <= yt_im[l];
                y_re[bot_idx[l]] <= yb_re[l];
                y_im[bot_idx[l]] <= yb_im[l];
            end
            ovf_q <= ovf_q | (|sat_v);
        end else if (accept) begin
            ovf_q <= 1'b0;
        end
    end

    always_comb begin
        bus.out_real = '0;
        bus.out_imag = '0;
        for (int k = 0; k < N_PTS; k++) begin
            bus.out_real[k*DW +: DW] = y_re[k];
            bus.out_imag[k*DW +: DW] = y_im[k];
        end
    end
endmodule

// File: tb/tb_fft_stage_seq.sv
// Directed bench for fft_stage_seq: default 4-lane/span-16 instance plus a
// 16-lane/span-1 instance, with hand-computed expected butterfly outputs.
module tb_fft_stage_seq;
    localparam int N  = 32;
    localparam int DW = 10;
    localparam int NB = N / 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fft_stage_seq_if #(.N_PTS(N), .DW(DW)) bus_a ();
    fft_stage_seq_if #(.N_PTS(N), .DW(DW)) bus_b ();

    fft_stage_seq #(.N_PTS(N), .DW(DW), .FRAC(5), .LANES(4), .SPAN(16)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    fft_stage_seq #(.N_PTS(N), .DW(DW), .FRAC(5), .LANES(16), .SPAN(1)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int lat;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] rep_s(input int v);
        logic [DW-1:0] e;
        e = v[DW-1:0];
        for (int k = 0; k < N; k++) rep_s[k*DW +: DW] = e;
    endfunction

    function automatic logic [NB*DW-1:0] rep_w(input int v);
        logic [DW-1:0] e;
        e = v[DW-1:0];
        for (int k = 0; k < NB; k++) rep_w[k*DW +: DW] = e;
    endfunction

    task automatic set_a(input int sr, input int si, input int wr, input int wi, input bit sc);
        bus_a.in_real  = rep_s(sr);
        bus_a.in_imag  = rep_s(si);
        bus_a.tw_real  = rep_w(wr);
        bus_a.tw_imag  = rep_w(wi);
        bus_a.scale_en = sc;
    endtask

    task automatic accept_a();
        for (int i = 0; i < 50 && !bus_a.in_ready; i++) begin
            @(posedge clk); #1;
        end
        bus_a.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
    endtask

    task automatic wait_out_a(output int n);
        n = 0;
        while (!bus_a.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic release_a();
        bus_a.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_a.out_ready = 1'b0;
    endtask

    task automatic check_frame(input string t, input logic [N*DW-1:0] ore,
                               input logic [N*DW-1:0] oim, input int span,
                               input longint tr, input longint ti,
                               input longint br, input longint bi);
        bit top;
        for (int k = 0; k < N; k++) begin
            top = ((k / span) % 2) == 0;
            check($sformatf("%s re[%0d]", t, k), $signed(ore[k*DW +: DW]), top ? tr : br);
            check($sformatf("%s im[%0d]", t, k), $signed(oim[k*DW +: DW]), top ? ti : bi);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        bus_a.in_valid = 0; bus_a.out_ready = 0; set_a(0, 0, 0, 0, 0);
        bus_b.in_valid = 0; bus_b.out_ready = 0;
        bus_b.in_real = '0; bus_b.in_imag = '0; bus_b.tw_real = '0; bus_b.tw_imag = '0;
        bus_b.scale_en = 0;
        repeat (2) @(posedge clk); #1;

        check("rst out_valid", bus_a.out_valid, 0);
        check("rst in_ready", bus_a.in_ready, 0);
        check("rst busy", bus_a.busy, 0);
        check("rst ovf", bus_a.ovf, 0);
        check("rst out_real", |bus_a.out_real, 0);
        rst = 1'b1;
        #1;
        check("idle in_ready", bus_a.in_ready, 1);

        // Basic frame: p = 1+1j, top 2+2j, bot 0.
        set_a(1, 1, 32, 0, 0);
        accept_a();
        check("t1 busy", bus_a.busy, 1);
        wait_out_a(lat);
        check("t1 latency", lat, 4);
        check_frame("t1", bus_a.out_real, bus_a.out_imag, 16, 2, 2, 0, 0);
        check("t1 ovf", bus_a.ovf, 0);
        check("t1 in_ready in DONE", bus_a.in_ready, 0);
        release_a();
        check("t1 out_valid after take", bus_a.out_valid, 0);

        // Twiddle -j: p = 0-32j after round half-up.
        set_a(32, 0, 0, -32, 0);
        accept_a(); wait_out_a(lat);
        check("t2a latency", lat, 4);
        check_frame("t2a", bus_a.out_real, bus_a.out_imag, 16, 32, -32, 32, 32);
        release_a();

        // 1*16 = 16, +16 rounds up to 1.
        set_a(1, 0, 16, 0, 0);
        accept_a(); wait_out_a(lat);
        check_frame("t2b", bus_a.out_real, bus_a.out_imag, 16, 2, 0, 0, 0);
        check("t2b ovf", bus_a.ovf, 0);
        release_a();

        // 511+511 saturates; the halved version does not.
        set_a(511, 0, 32, 0, 0);
        accept_a(); wait_out_a(lat);
        check_frame("t3a", bus_a.out_real, bus_a.out_imag, 16, 511, 0, 0, 0);
        check("t3a ovf", bus_a.ovf, 1);
        release_a();
        set_a(511, 0, 32, 0, 1);
        accept_a(); wait_out_a(lat);
        check_frame("t3b", bus_a.out_real, bus_a.out_imag, 16, 511, 0, 0, 0);
        check("t3b ovf", bus_a.ovf, 0);
        release_a();

        // Backpressure with a competing frame offered during DONE.
        set_a(511, 0, 32, 0, 0);
        accept_a(); wait_out_a(lat);
        check("t4 latency", lat, 4);
        set_a(1, 1, 32, 0, 0);
        bus_a.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check($sformatf("t4 hold out_valid c%0d", i), bus_a.out_valid, 1);
            check($sformatf("t4 hold in_ready c%0d", i), bus_a.in_ready, 0);
            check($sformatf("t4 hold ovf c%0d", i), bus_a.ovf, 1);
            check($sformatf("t4 hold re0 c%0d", i), $signed(bus_a.out_real[0 +: DW]), 511);
        end
        check_frame("t4 held", bus_a.out_real, bus_a.out_imag, 16, 511, 0, 0, 0);
        bus_a.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_a.out_ready = 1'b0;
        check("t4 out_valid after take", bus_a.out_valid, 0);
        check("t4 in_ready after take", bus_a.in_ready, 1);
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        check("t4 accepted next cycle", bus_a.busy, 1);
        wait_out_a(lat);
        check("t4b latency", lat, 4);
        check_frame("t4b", bus_a.out_real, bus_a.out_imag, 16, 2, 2, 0, 0);
        check("t4b ovf", bus_a.ovf, 0);
        release_a();

        // Reset two cycles into CALC drops the saturating frame.
        set_a(511, 0, 32, 0, 0);
        accept_a();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("t5 out_valid", bus_a.out_valid, 0);
        check("t5 in_ready", bus_a.in_ready, 0);
        check("t5 busy", bus_a.busy, 0);
        check("t5 ovf", bus_a.ovf, 0);
        check("t5 out_real cleared", |bus_a.out_real, 0);
        repeat (2) @(posedge clk);
        #1;
        check("t5 out_valid in reset", bus_a.out_valid, 0);
        rst = 1'b1;
        #1;
        check("t5 in_ready after release", bus_a.in_ready, 1);
        set_a(1, 1, 32, 0, 0);
        accept_a(); wait_out_a(lat);
        check("t5 latency", lat, 4);
        check_frame("t5", bus_a.out_real, bus_a.out_imag, 16, 2, 2, 0, 0);
        check("t5 frame ovf", bus_a.ovf, 0);
        release_a();

        // Fully parallel instance: one cycle, adjacent pairs.
        bus_b.in_real = rep_s(1); bus_b.in_imag = rep_s(1);
        bus_b.tw_real = rep_w(32); bus_b.tw_imag = rep_w(0);
        bus_b.scale_en = 1'b0;
        for (int i = 0; i < 20 && !bus_b.in_ready; i++) begin
            @(posedge clk); #1;
        end
        bus_b.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_b.in_valid = 1'b0;
        lat = 0;
        while (!bus_b.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("t6 latency", lat, 1);
        check_frame("t6", bus_b.out_real, bus_b.out_imag, 1, 2, 2, 0, 0);
        check("t6 ovf", bus_b.ovf, 0);
        bus_b.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_b.out_ready = 1'b0;
        check("t6 out_valid after take", bus_b.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_stage_seq.md
Name: fft_stage_seq

Overview:
Parametrised, time-multiplexed radix-2 FFT stage with a valid/ready handshake on both sides. It accepts one frame of N_PTS complex samples plus N_PTS/2 per-butterfly twiddles. It computes LANES butterflies per cycle, then presents the full result frame. It succeeds the fixed 32-point, 16-butterfly stage and external butterfly FSM, and adds:
- selectable span,
- lane count,
- per-stage scaling,
- saturation with an overflow flag,
- backpressure.

Parameters:
N_PTS, 32, complex points per frame (power of 2, >=4)
DW, 10, signed sample/twiddle width
FRAC, 5, twiddle fraction bits (1.0 = 1<<FRAC)
LANES, 4, butterflies per cycle; must divide N_PTS/2
SPAN, 16, butterfly distance (power of 2, <= N_PTS/2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
in_valid  in  1  input frame valid
in_ready  out  1  stage can accept a frame
in_real  in  N_PTS*DW  sample k at [k*DW +: DW], signed
in_imag  in  N_PTS*DW  as in_real
tw_real  in  (N_PTS/2)*DW  twiddle for butterfly b at [b*DW +: DW]
tw_imag  in  (N_PTS/2)*DW  as tw_real
scale_en  in  1  halve butterfly outputs; sampled at frame accept
out_valid  out  1  result frame valid
out_ready  in  1  downstream accepts result
out_real  out  N_PTS*DW  result, same packing as input
out_imag  out  N_PTS*DW  as out_real
busy  out  1  state != IDLE
ovf  out  1  sticky saturation flag for current frame

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, counter=0.
  - out_valid=0, ovf=0, busy=0, out_real/out_imag=0.
  - in_ready is forced 0 while rst is low.
  - A reset mid-frame discards that frame with no output.
- States:
  - IDLE -> CALC on in_valid&in_ready. At this edge, capture in_*, tw_*, scale_en; clear ovf; counter=0.
  - CALC: each cycle process butterflies b = counter*LANES .. +LANES-1 and write results into the output buffer; counter++. After C = N_PTS/(2*LANES) cycles -> DONE.
  - DONE: out_valid=1. On out_valid&out_ready -> IDLE.
- in_ready = (state==IDLE) & rst. No overlap of frames. Minimum period is C+2 cycles per frame.
- Latency: if accept occurs at edge E, out_valid rises at edge E+C. out_real/out_imag/ovf are stable while out_valid=1 & !out_ready.
- Butterfly b indexing:
  - g = b/SPAN, j = b%SPAN.
  - top = g*2*SPAN + j, bot = top + SPAN.
  - Twiddle w = tw[b].
- Butterfly arithmetic:
  - p = x[bot]*w, complex: pr = br*wr - bi*wi, pi = br*wi + bi*wr.
  - Products are full 2*DW bits, summed at 2*DW+1 bits.
  - Round half-up: add 1<<(FRAC-1), then arithmetic shift right by FRAC.
  - y[top] = a + p, y[bot] = a - p, computed at DW+2 bits.
  - If scale_en, arithmetic shift right 1 (floor).
  - Saturate each component to [-2^(DW-1), 2^(DW-1)-1]. Any clip sets ovf, which stays set until the next accept.
- in_valid while not ready: ignored, no capture. out_ready while !out_valid: ignored.

Decomposition:
- Shared package/include fft_defs holds:
  - the DW/FRAC defaults,
  - a complex-sample typedef (re, im signed DW),
  - the round-shift and saturate functions shared across FFT blocks.
- One sub-module, fft_bfly_r2: a purely combinational single butterfly (inputs a, b, w, scale_en; outputs y_top, y_bot, sat). Instantiate it LANES times.
- The FSM, counter, buffers and operand muxing stay in fft_stage_seq.

Test Plan:
1. Defaults; all samples 1+1j, all twiddles 32+0j, scale_en=0 -> out_valid exactly 4 cycles after accept. Every top = 2+2j, every bot = 0+0j, ovf=0.
2. All samples 32+0j, twiddles 0-32j -> top = 32-32j, bot = 32+32j. Samples 1+0j with twiddle 16+0j -> p=1 via rounding, top=2, bot=0.
3. All samples 511+0j, twiddle 32+0j:
   - scale_en=0 -> top=511 (saturated), ovf=1.
   - Next frame with scale_en=1 -> top=511 unsaturated (1022>>1), bot=0, ovf=0.
4. Hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, data and ovf unchanged, in_ready=0. A frame offered meanwhile is not captured; it is accepted in the cycle after out_ready=1.
5. Drive rst low 2 cycles into CALC -> out_valid=0 and in_ready=0 immediately. After release, a new frame (test 1 data) completes correctly with no stale output.
6. Rerun test 1 with LANES=16, SPAN=1 -> out_valid 1 cycle after accept, pairs (2k, 2k+1) give 2+2j / 0+0j.
